ysyx_23060278_exec_ctrl: RTL
============================

// Module: ysyx_23060278_exec_ctrl
// PURPOSE
//  Multi-cycle core sequencer. Drives fetch and LSU valid/ready handshakes and the write enables of
//  the PC register, instruction register and GPR write port, one instruction at a time.
//  Sits between the IFU/LSU bus masters and the datapath registers. Flags halt (ebreak) and bus timeout.
// PARAMETERS
//  TIMEOUT    256  max cycles spent in a REQ/WAIT state before ERR; 0 = timeout disabled
//  TMO_W      9    timer width; must satisfy 2**TMO_W > TIMEOUT
//  CNT_W      64   width of retired-instruction counter
// PORTS
//  clk            in   1      single clock, rising edge
//  rst            in   1      asynchronous reset, active-high
//  ifu_req_valid  out  1      fetch request (PC stable in datapath)
//  ifu_req_ready  in   1      IFU accepts request
//  ifu_resp_valid in   1      instruction word available
//  ifu_resp_ready out  1      controller accepts instruction
//  dec_is_mem     in   1      decoded inst is load/store (stable from DECODE to WB)
//  dec_wen_rd     in   1      decoded inst writes rd
//  dec_halt       in   1      decoded inst is ebreak
//  lsu_req_valid  out  1      memory request
//  lsu_req_ready  in   1      LSU accepts request
//  lsu_resp_valid in   1      LSU done (load data / store ack)
//  lsu_resp_ready out  1      controller accepts LSU response
//  inst_wen       out  1      instruction register write enable
//  gpr_wen        out  1      GPR file write enable
//  pc_wen         out  1      PC register write enable (next PC)
//  halt           out  1      sticky: ebreak decoded
//  err            out  1      sticky: bus timeout
//  state          out  4      current state, for debug/difftest
//  inst_cnt       out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset: state=IDLE, timer=0, inst_cnt=0, halt=err=0. All outputs decode from state, so every
//   valid/ready/wen drops as soon as rst asserts. Mid-transaction requests are abandoned, never replayed.
//  States and transitions (one register, 4-bit encoding):
//   IDLE       -> FETCH_REQ unconditionally (one cycle after rst release)
//   FETCH_REQ  ifu_req_valid=1, held until ifu_req_ready; then -> FETCH_WAIT
//   FETCH_WAIT ifu_resp_ready=1; on ifu_resp_valid: inst_wen=1 same cycle (Mealy), -> DECODE
//   DECODE     one cycle; dec_halt ? -> HALT : -> EXEC
//   EXEC       one cycle; dec_is_mem ? -> MEM_REQ : -> WB
//   MEM_REQ    lsu_req_valid=1, held until lsu_req_ready; then -> MEM_WAIT
//   MEM_WAIT   lsu_resp_ready=1; on lsu_resp_valid -> WB
//   WB         gpr_wen=dec_wen_rd, pc_wen=1, inst_cnt+=1 (wraps at 2**CNT_W); -> FETCH_REQ
//   HALT       halt=1, terminal until reset; no bus activity
//   ERR        err=1, terminal until reset; no bus activity
//  Latency with zero-wait bus: 5 cycles for a non-mem inst, 7 for load/store (FETCH_REQ to WB inclusive).
//  Handshakes: valid never deasserts before ready. Responses arriving while resp_ready=0 are ignored.
//  Timer: increments each cycle in FETCH_REQ/FETCH_WAIT/MEM_REQ/MEM_WAIT and clears on any state change.
//   Handshake not completed with timer==TIMEOUT-1 -> ERR next cycle.
//   Handshake completing in that same cycle wins (normal transition, no ERR).
//  inst_wen, gpr_wen and pc_wen are each asserted for exactly one cycle per instruction, never in HALT/ERR.
//  An ebreak is not retired: no pc_wen, and inst_cnt is not incremented.
// STRUCTURE
//  Package ysyx_23060278_ctrl_pkg: state enum values (IDLE=0 .. ERR=9), default TIMEOUT.
//  Sub-module ysyx_23060278_wait_timer (clear, enable, expire output).
//  FSM next-state logic and output decode stay in this module.
//  State, timer and counter registers use async-reset flops. Outputs are combinational from state and inputs.
// TESTING
//  Zero-wait bus, 3 ALU insts (dec_wen_rd=1) -> inst_wen/gpr_wen/pc_wen pulse every 5 cycles; inst_cnt=3.
//  Load with lsu_req_ready delayed 4 cycles -> lsu_req_valid held 5 cycles; WB 11 cycles after FETCH_REQ.
//  Store (dec_wen_rd=0) -> gpr_wen stays 0; pc_wen=1 in WB; inst_cnt increments.
//  dec_halt=1 -> DECODE->HALT; halt=1 sticky; no further ifu_req_valid for 100 cycles; inst_cnt unchanged.
//  TIMEOUT=8, ifu_resp_valid never set -> err=1, state=ERR 8 cycles into FETCH_WAIT.
//   Repeat with resp_valid on cycle 8 -> no err.
//  rst asserted during MEM_WAIT -> lsu_resp_ready=0 immediately; after release IDLE->FETCH_REQ; counters 0.

Source files
------------

// File: rtl/ysyx_23060278_exec_ctrl_pkg.sv
// Shared types and defaults for the multi-cycle execution sequencer.
package ysyx_23060278_ctrl_pkg;

  // Sequencer states; the encoding is exported on the debug/difftest port.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH_REQ  = 4'd1,
    FETCH_WAIT = 4'd2,
    DECODE     = 4'd3,
    EXEC       = 4'd4,
    MEM_REQ    = 4'd5,
    MEM_WAIT   = 4'd6,
    WB         = 4'd7,
    HALT       = 4'd8,
    ERR        = 4'd9
  } ctrl_state_e;

  // Cycles a bus handshake may stall before the core gives up.
  localparam int DEFAULT_TIMEOUT = 256;

  // States in which the sequencer is waiting on a bus handshake.
  function automatic logic is_bus_state(ctrl_state_e s);
    return (s == FETCH_REQ) || (s == FETCH_WAIT) || (s == MEM_REQ) || (s == MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_23060278_exec_ctrl_if.sv
// Fetch and LSU valid/ready handshakes between the sequencer and the bus masters.
interface ysyx_23060278_exec_ctrl_if;

  logic ifu_req_valid;
  logic ifu_req_ready;
  logic ifu_resp_valid;
  logic ifu_resp_ready;
  logic lsu_req_valid;
  logic lsu_req_ready;
  logic lsu_resp_valid;
  logic lsu_resp_ready;

  // Sequencer side: issues requests and accepts responses.
  modport master (
    output ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid
  );

  // Bus side: accepts requests and returns responses.
  modport slave (
    input  ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid
  );

endinterface

// File: rtl/ysyx_23060278_exec_ctrl_wait_timer.sv
// Stall timer: counts cycles spent waiting on one handshake and flags the last allowed cycle.
module ysyx_23060278_wait_timer #(
  parameter int TIMEOUT = 256,
  parameter int TMO_W   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // A zero TIMEOUT disables expiry; the compare value is then irrelevant.
  localparam logic [TMO_W-1:0] LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] count;

  // Cycle counter, restarted whenever the sequencer changes state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      count <= '0;
    end else if (enable) begin
      count <= count + TMO_W'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/ysyx_23060278_exec_ctrl.sv
// Multi-cycle core sequencer: fetch, decode, execute, optional memory access, write-back.
module ysyx_23060278_exec_ctrl
  import ysyx_23060278_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TMO_W   = 9,
  parameter int CNT_W   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_23060278_exec_ctrl_if.master bus,
  input  logic                      dec_is_mem,
  input  logic                      dec_wen_rd,
  input  logic                      dec_halt,
  output logic                      inst_wen,
  output logic                      gpr_wen,
  output logic                      pc_wen,
  output logic                      halt,
  output logic                      err,
  output logic [3:0]                state,
  output logic [CNT_W-1:0]          inst_cnt
);

  ctrl_state_e cur_state;
  ctrl_state_e nxt_state;
  logic        tmo_expire;

  ysyx_23060278_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (nxt_state != cur_state),
    .enable (is_bus_state(cur_state)),
    .expire (tmo_expire)
  );

  // Next-state selection; a handshake completing on the expiry cycle takes priority over ERR.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves nxt_state unassigned (no latch).
    nxt_state = cur_state;
    case (cur_state)
      IDLE:       nxt_state = FETCH_REQ;
      FETCH_REQ:  if (bus.ifu_req_ready)       nxt_state = FETCH_WAIT;
                  else if (tmo_expire)         nxt_state = ERR;
      FETCH_WAIT: if (bus.ifu_resp_valid)      nxt_state = DECODE;
                  else if (tmo_expire)         nxt_state = ERR;
      DECODE:     nxt_state = dec_halt ? HALT : EXEC;
      EXEC:       nxt_state = dec_is_mem ? MEM_REQ : WB;
      MEM_REQ:    if (bus.lsu_req_ready)       nxt_state = MEM_WAIT;
                  else if (tmo_expire)         nxt_state = ERR;
      MEM_WAIT:   if (bus.lsu_resp_valid)      nxt_state = WB;
                  else if (tmo_expire)         nxt_state = ERR;
      WB:         nxt_state = FETCH_REQ;
      HALT, ERR:  nxt_state = cur_state;
      default:    nxt_state = IDLE;
    endcase
  end

  // State register; HALT and ERR hold until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  // Retired-instruction counter; ebreak never reaches WB so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  inst_cnt <= '0;
    else if (cur_state == WB) inst_cnt <= inst_cnt + CNT_W'(1);
  end

  // Outputs decode straight from the state so reset silences them immediately.
  assign bus.ifu_req_valid  = (cur_state == FETCH_REQ);
  assign bus.ifu_resp_ready = (cur_state == FETCH_WAIT);
  assign bus.lsu_req_valid  = (cur_state == MEM_REQ);
  assign bus.lsu_resp_ready = (cur_state == MEM_WAIT);
  assign inst_wen           = (cur_state == FETCH_WAIT) && bus.ifu_resp_valid;
  assign gpr_wen            = (cur_state == WB) && dec_wen_rd;
  assign pc_wen             = (cur_state == WB);
  assign halt               = (cur_state == HALT);
  assign err                = (cur_state == ERR);
  assign state              = cur_state;

endmodule
